bf16_acc_ctrl: RTL and testbench
================================

BF16_ACC_CTRL -- requirements
Module: bf16_acc_ctrl

Interface
REQ-001 Parameter: LEN_W, 8, width of the vector-length input and element counter.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request a new accumulation; sampled only in IDLE.
REQ-005 Port: len  input  LEN_W  number of elements to accumulate; sampled with start.
REQ-006 Port: in_valid  input  1  element present on in_data.
REQ-007 Port: in_data  input  16  BF16 element.
REQ-008 Port: in_ready  output  1  block accepts an element this cycle.
REQ-009 Port: out_valid  output  1  result present on out_data / out_nan.
REQ-010 Port: out_data  output  16  BF16 accumulated sum.
REQ-011 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-012 Port: out_nan  output  1  a NaN was produced at any step of this accumulation.
REQ-013 Port: busy  output  1  high in every state other than IDLE.

Function
REQ-014 The block shall instantiate exactly one adder_bf16, with A = acc register, B = in_data, and S as the next-acc value; no other adder shall exist.
REQ-015 The states shall be IDLE, ACC and DONE, encoded in one state register.
REQ-016 IDLE: in_ready=0, out_valid=0; start=1 with len!=0 -> ACC, acc<=16'h0000, cnt<=len, nan flag<=0.
REQ-017 IDLE: start=1 with len==0 -> DONE directly, acc<=16'h0000, nan flag<=0.
REQ-018 ACC: in_ready=1 combinationally; an element is accepted in a cycle with in_valid=1.
REQ-019 On acceptance: acc<=S, cnt<=cnt-1, and nan flag |= (S[14:7]==8'hFF && S[6:0]!=0).
REQ-020 ACC -> DONE on the accepting cycle where cnt==1; cycles with in_valid=0 leave all state unchanged.
REQ-021 DONE: out_valid=1, out_data=acc, out_nan=nan flag, in_ready=0; out_valid is asserted on the cycle after the last element is accepted (latency 1).
REQ-022 DONE with out_ready=1 -> IDLE; with out_ready=0, the state and out_data/out_nan shall be held stable.
REQ-023 start shall be ignored in ACC and DONE; len is not re-sampled.
REQ-024 The counter shall never wrap: len = 2^LEN_W-1 accepts exactly that many elements.
REQ-025 A start in the same cycle as the DONE->IDLE handshake shall be ignored; a new start is taken in IDLE only.
REQ-026 Outputs out_data and out_nan shall be driven from registers only; in_ready, out_valid and busy shall decode from state only.

Reset
REQ-027 When rst=1 at a clock edge: state<=IDLE, acc<=16'h0000, cnt<=0, nan flag<=0; rst has priority over all other inputs.
REQ-028 After reset: in_ready=0, out_valid=0, out_data=16'h0000, out_nan=0, busy=0.
REQ-029 rst during ACC or DONE shall abort the operation; any partial sum is discarded and no out_valid follows.

Verification
REQ-030 start, len=1, in_data=16'h3F80 -> out_valid the next cycle, out_data=16'h3F80, out_nan=0.
REQ-031 len=3 with elements 16'h3F80, 16'h0000, 16'h0000, and in_valid gaps between them -> out_data=16'h3F80; accepted-element count is exactly 3.
REQ-032 len=2 with elements 16'h7F80, 16'hFF80 -> out_data=16'h7F81, out_nan=1; a following len=1 run with 16'h3F80 -> out_nan=0.
REQ-033 len=0 start -> out_valid the next cycle, out_data=16'h0000, with no in_ready pulse.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stay stable; start pulses in that window are ignored, and busy=1 throughout.
REQ-035 Assert rst after 2 of 4 elements -> state is IDLE on the next cycle, busy=0, and no out_valid; a fresh len=1 run with 16'h7F80 -> out_data=16'h7F80.

Source files
------------

// File: rtl/bf16_acc_ctrl.sv
// BF16 vector accumulator: sums len elements through one BF16 adder
// and presents the sum with a sticky NaN flag on a valid/ready output.

// BF16 adder, round toward zero, subnormals flushed to zero.
// Every NaN result is the single pattern 16'h7F81.
module adder_bf16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s
);

    logic        a_nan, b_nan, a_inf, b_inf;
    logic        swap;
    logic [15:0] x, y;
    logic [7:0]  mx, my, d;
    logic [15:0] ax, ay;
    logic [16:0] sum, norm;
    logic [4:0]  p;
    logic [9:0]  er;

    // Align the smaller magnitude, add or subtract, then renormalise.
    always_comb begin
        a_nan = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
        b_nan = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
        a_inf = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
        b_inf = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
        swap  = b[14:0] > a[14:0];
        x     = swap ? b : a;
        y     = swap ? a : b;
        mx    = (x[14:7] != 8'h00) ? {1'b1, x[6:0]} : 8'h00;
        my    = (y[14:7] != 8'h00) ? {1'b1, y[6:0]} : 8'h00;
        d     = x[14:7] - y[14:7];
        ax    = {mx, 8'h00};
        ay    = (d > 8'd15) ? 16'h0000 : ({my, 8'h00} >> d);
        if (x[15] == y[15])
            sum = {1'b0, ax} + {1'b0, ay};
        else
            sum = {1'b0, ax} - {1'b0, ay};
        p = 5'd0;
        for (int i = 0; i < 17; i++)
            if (sum[i]) p = 5'(i);
        norm = sum << (5'd16 - p);
        er   = {2'b00, x[14:7]} + {5'b00000, p};
        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15])))
            s = 16'h7F81;
        else if (a_inf)
            s = a;
        else if (b_inf)
            s = b;
        else if (sum == 17'h0)
            s = 16'h0000;
        else if (er <= 10'd15)
            s = {x[15], 15'h0000};
        else if (er >= 10'd270)
            s = {x[15], 8'hFF, 7'h00};
        else
            s = {x[15], 8'(er - 10'd15), norm[15:9]};
    end

endmodule

module bf16_acc_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [15:0]      out_data,
    input  logic             out_ready,
    output logic             out_nan,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [15:0]      acc;
    logic [LEN_W-1:0] cnt;
    logic             nan_f;
    logic [15:0]      sum;
    logic             sum_nan;

    adder_bf16 u_add (
        .a (acc),
        .b (in_data),
        .s (sum)
    );

    assign sum_nan = (sum[14:7] == 8'hFF) && (sum[6:0] != 7'h00);

    // Handshake and status flags decode from state alone.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = acc;
    assign out_nan   = nan_f;

    // Control FSM with accumulator, element counter and sticky NaN flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= 16'h0000;
            cnt   <= '0;
            nan_f <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= 16'h0000;
                        nan_f <= 1'b0;
                        cnt   <= len;
                        state <= (len != '0) ? ACC : DONE;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc   <= sum;
                        cnt   <= cnt - 1'b1;
                        nan_f <= nan_f | sum_nan;
                        if (cnt == {{(LEN_W-1){1'b0}}, 1'b1})
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_acc_ctrl.sv
// Scoreboard bench for bf16_acc_ctrl: integer-exact random vectors
// plus infinities and NaNs, checked against an abstract sum model.
module tb_bf16_acc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        out_nan;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // kind: 0 finite integer, 1 +inf, 2 -inf, 3 NaN
    typedef struct {
        int kind;
        int v;
    } elem_t;

    typedef struct {
        logic [15:0] d;
        logic        n;
    } exp_t;

    exp_t  sb[$];
    elem_t cur[$];

    bf16_acc_ctrl #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_nan   (out_nan),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] int2bf(input int v);
        int m;
        int k;
        logic [7:0] e8;
        logic [6:0] f;
        if (v == 0) return 16'h0000;
        m = (v < 0) ? -v : v;
        k = 0;
        for (int i = 0; i < 9; i++)
            if (((m >> i) & 1) != 0) k = i;
        e8 = 8'(127 + k);
        f  = 7'((m << (7 - k)) & 'h7F);
        return {(v < 0), e8, f};
    endfunction

    function automatic logic [15:0] enc(input elem_t e);
        case (e.kind)
            1:       return 16'h7F80;
            2:       return 16'hFF80;
            3:       return 16'h7FC0;
            default: return int2bf(e.v);
        endcase
    endfunction

    // Running value is an exact integer unless an infinity or NaN arrives.
    task automatic model(input elem_t es[$], output exp_t r);
        int  k   = 0;
        int  v   = 0;
        bit  nan = 0;
        foreach (es[i]) begin
            if (k == 3 || es[i].kind == 3)
                k = 3;
            else if (k == 1 || k == 2) begin
                if (es[i].kind != 0 && es[i].kind != k) k = 3;
            end else if (es[i].kind != 0)
                k = es[i].kind;
            else
                v += es[i].v;
            if (k == 3) nan = 1;
        end
        case (k)
            1:       r.d = 16'h7F80;
            2:       r.d = 16'hFF80;
            3:       r.d = 16'h7F81;
            default: r.d = int2bf(v);
        endcase
        r.n = nan;
    endtask

    // Output monitor: every accepted result must match the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0)
                check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.d));
                check("out_nan", 32'(out_nan), 32'(e.n));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input elem_t es[$], input int gaps);
        foreach (es[i]) begin
            int t;
            repeat ($urandom_range(0, gaps)) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data  = enc(es[i]);
            t = 0;
            while (!in_ready && t < 20) begin
                tick();
                t++;
            end
            check("in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic run(input elem_t es[$], input int gaps, input bit hold);
        exp_t e;
        model(es, e);
        sb.push_back(e);
        tick();
        start = 1'b1;
        len   = 8'(es.size());
        tick();
        start = 1'b0;
        feed(es, gaps);
        check("latency_valid", 32'(out_valid), 32'd1);
        check("done_in_ready", 32'(in_ready), 32'd0);
        if (!hold) begin
            tick();
            check("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    function automatic elem_t fin(input int v);
        elem_t e;
        e.kind = 0;
        e.v    = v;
        return e;
    endfunction

    function automatic elem_t spc(input int k);
        elem_t e;
        e.kind = k;
        e.v    = 0;
        return e;
    endfunction

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_nan", 32'(out_nan), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        cur = {fin(1)};
        run(cur, 0, 0);

        cur = {fin(1), fin(0), fin(0)};
        run(cur, 3, 0);

        cur = {spc(1), spc(2)};
        run(cur, 1, 0);
        cur = {fin(1)};
        run(cur, 0, 0);

        cur = {};
        run(cur, 0, 0);

        out_ready = 1'b0;
        cur = {fin(1)};
        run(cur, 0, 1);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'h3F80);
            check("hold_busy", 32'(busy), 32'd1);
            start = i[0];
            len   = 8'd3;
            tick();
        end
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("hs_start_ignored", 32'(busy), 32'd0);
        tick();
        check("idle_after_hs", 32'(busy), 32'd0);

        cur = {fin(3), fin(4), fin(5), fin(6)};
        tick();
        start = 1'b1;
        len   = 8'd4;
        tick();
        start = 1'b0;
        cur = {fin(3), fin(4)};
        feed(cur, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        repeat (3) begin
            tick();
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        cur = {spc(1)};
        run(cur, 0, 0);

        cur = {};
        for (int i = 0; i < 255; i++)
            cur.push_back(fin(int'($urandom_range(0, 1))));
        run(cur, 0, 0);

        for (int r = 0; r < 40; r++) begin
            int n;
            n   = $urandom_range(1, 8);
            cur = {};
            for (int i = 0; i < n; i++) begin
                int k;
                k = $urandom_range(0, 24);
                if (k == 0)      cur.push_back(spc(1));
                else if (k == 1) cur.push_back(spc(2));
                else if (k == 2) cur.push_back(spc(3));
                else cur.push_back(fin(int'($urandom_range(0, 62)) - 31));
            end
            run(cur, 2, 0);
        end

        tick();
        tick();
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
